// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - LEGv8 writeback stage committing one register-file write per retiring instruction; optional load timeout under WB_MEM_TIMEOUT_EN
module writeback_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   wbStart,
   input  logic                   wbRegWrite,
   input  logic                   memToReg,
   input  logic                   link,
   input  logic [4:0]             destReg,
   input  logic [DATA_WIDTH-1:0]  aluResult,
   input  logic [DATA_WIDTH-1:0]  pcPlus4,
   input  logic [DATA_WIDTH-1:0]  memReadData,
   input  logic                   memDataValid,
   output logic                   regWrite,
   output logic [4:0]             writeRegister,
   output logic [DATA_WIDTH-1:0]  writeData,
   output logic                   busy,
   output logic                   wbDone,
   output logic [COUNT_WIDTH-1:0] wbCount,
   output logic                   memTimeout
);

   localparam logic [4:0] LINK_REG = 5'd30;
   localparam logic [4:0] ZERO_REG = 5'd31;

   // a zero timeout would abort every load before its data could arrive
   if (MEM_TIMEOUT < 1) begin : g_timeout_range
      $error("MEM_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT_MEM,
      WRITE
   } state_t;

   state_t                  state, state_nxt;
   logic [4:0]              cap_reg, cap_reg_nxt;
   logic [DATA_WIDTH-1:0]   cap_data, cap_data_nxt;
   logic                    reg_write_nxt;
   logic [4:0]              write_register_nxt;
   logic [DATA_WIDTH-1:0]   write_data_nxt;
   logic                    wb_done_nxt;
   logic [COUNT_WIDTH-1:0]  wb_count_nxt;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   logic [TW-1:0]           to_cnt, to_cnt_nxt;
   logic                    mem_timeout_nxt;
`endif

   assign busy = (state != IDLE);

   // state, capture and output registers; reset clears everything and aborts any instruction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cap_reg       <= '0;
         cap_data      <= '0;
         regWrite      <= 1'b0;
         writeRegister <= '0;
         writeData     <= '0;
         wbDone        <= 1'b0;
         wbCount       <= '0;
`ifdef WB_MEM_TIMEOUT_EN
         to_cnt        <= '0;
         memTimeout    <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         cap_reg       <= cap_reg_nxt;
         cap_data      <= cap_data_nxt;
         regWrite      <= reg_write_nxt;
         writeRegister <= write_register_nxt;
         writeData     <= write_data_nxt;
         wbDone        <= wb_done_nxt;
         wbCount       <= wb_count_nxt;
`ifdef WB_MEM_TIMEOUT_EN
         to_cnt        <= to_cnt_nxt;
         memTimeout    <= mem_timeout_nxt;
`endif
      end
   end

`ifndef WB_MEM_TIMEOUT_EN
   assign memTimeout = 1'b0;
`endif

   // next-state and next-output logic; the destination and data source are resolved at capture time
   always_comb begin
      state_nxt          = state;
      cap_reg_nxt        = cap_reg;
      cap_data_nxt       = cap_data;
      reg_write_nxt      = 1'b0;
      write_register_nxt = writeRegister;
      write_data_nxt     = writeData;
      wb_done_nxt        = 1'b0;
      wb_count_nxt       = wbCount;
`ifdef WB_MEM_TIMEOUT_EN
      to_cnt_nxt         = to_cnt;
      mem_timeout_nxt    = memTimeout;
`endif
      case (state)
         IDLE: begin
            if (wbStart) begin
               cap_reg_nxt  = destReg;
               cap_data_nxt = aluResult;
               if (!wbRegWrite) begin
                  wb_done_nxt = 1'b1;
               end else if (link) begin
                  cap_reg_nxt  = LINK_REG;
                  cap_data_nxt = pcPlus4;
                  state_nxt    = WRITE;
               end else if (memToReg) begin
                  state_nxt  = WAIT_MEM;
`ifdef WB_MEM_TIMEOUT_EN
                  to_cnt_nxt = '0;
`endif
               end else begin
                  state_nxt = WRITE;
               end
            end
         end
         WAIT_MEM: begin
            if (memDataValid) begin
               cap_data_nxt = memReadData;
               state_nxt    = WRITE;
`ifdef WB_MEM_TIMEOUT_EN
            end else if (to_cnt == TW'(MEM_TIMEOUT - 1)) begin
               mem_timeout_nxt = 1'b1;
               wb_done_nxt     = 1'b1;
               state_nxt       = IDLE;
            end else begin
               to_cnt_nxt = to_cnt + TW'(1);
`endif
            end
         end
         WRITE: begin
            wb_done_nxt = 1'b1;
            state_nxt   = IDLE;
            if (cap_reg != ZERO_REG) begin
               reg_write_nxt      = 1'b1;
               write_register_nxt = cap_reg;
               write_data_nxt     = cap_data;
               wb_count_nxt       = wbCount + COUNT_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed bench for writeback_unit with a cycle-scheduled expectation model
module tb_writeback_unit;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NC = 4096;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          wbStart = 1'b0, wbRegWrite = 1'b0, memToReg = 1'b0, link = 1'b0;
   logic [4:0]    destReg = '0;
   logic [DW-1:0] aluResult = '0, pcPlus4 = '0, memReadData = '0;
   logic          memDataValid = 1'b0;
   logic          regWrite, busy, wbDone, memTimeout;
   logic [4:0]    writeRegister;
   logic [DW-1:0] writeData;
   logic [CW-1:0] wbCount;

   writeback_unit #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .MEM_TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .wbStart(wbStart), .wbRegWrite(wbRegWrite),
      .memToReg(memToReg), .link(link), .destReg(destReg), .aluResult(aluResult),
      .pcPlus4(pcPlus4), .memReadData(memReadData), .memDataValid(memDataValid),
      .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
      .busy(busy), .wbDone(wbDone), .wbCount(wbCount), .memTimeout(memTimeout)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // expectations scheduled per cycle (cycle k = state after the k-th rising edge)
   bit          e_rw[NC], e_done[NC], e_busy[NC], e_inc[NC], e_to[NC], e_rst[NC], e_xzr[NC];
   logic [4:0]  e_reg[NC];
   logic [31:0] e_data[NC];

   int n_vec = 0;
   int n_err = 0;
   bit checking = 1'b0;

   logic [CW-1:0] mcnt = '0;
   bit            mto = 1'b0;
   logic [4:0]    mreg = '0;
   logic [31:0]   mdata = '0;
   bit            known = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (checking && cyc < NC) begin
         if (e_rst[cyc]) begin
            mcnt = '0; mto = 1'b0; mreg = '0; mdata = '0; known = 1'b1;
         end
         if (e_inc[cyc]) mcnt = mcnt + CW'(1);
         if (e_rw[cyc]) begin
            mreg = e_reg[cyc]; mdata = e_data[cyc]; known = 1'b1;
         end
         if (e_xzr[cyc]) known = 1'b0;
         if (e_to[cyc]) mto = 1'b1;
         chk("cmp_regWrite", 32'(regWrite), 32'(e_rw[cyc]));
         chk("cmp_wbDone", 32'(wbDone), 32'(e_done[cyc]));
         chk("cmp_busy", 32'(busy), 32'(e_busy[cyc]));
         chk("cmp_wbCount", 32'(wbCount), 32'(mcnt));
         chk("cmp_memTimeout", 32'(memTimeout), 32'(mto));
         if (known) begin
            chk("cmp_writeRegister", 32'(writeRegister), 32'(mreg));
            chk("cmp_writeData", writeData, mdata);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic commit(input int c, input logic [4:0] d, input logic [31:0] v);
      e_done[c] = 1'b1;
      if (d == 5'd31) begin
         e_xzr[c] = 1'b1;
      end else begin
         e_rw[c] = 1'b1; e_reg[c] = d; e_data[c] = v; e_inc[c] = 1'b1;
      end
   endtask

   task automatic set_instr(input bit rw, input bit m2r, input bit lnk, input logic [4:0] d,
                            input logic [31:0] alu, input logic [31:0] pc);
      wbStart = 1'b1; wbRegWrite = rw; memToReg = m2r; link = lnk;
      destReg = d; aluResult = alu; pcPlus4 = pc;
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         e_rst[cyc + 1] = 1'b1;
         tick();
      end
      reset = 1'b0;
   endtask

   // ALU result: regWrite visible one cycle after the accepting edge; returns in that cycle
   task automatic alu(input logic [4:0] d, input logic [31:0] v);
      int e;
      e = cyc + 1;
      e_busy[e] = 1'b1;
      commit(e + 1, d, v);
      set_instr(1'b1, 1'b0, 1'b0, d, v, 32'h0000_4444);
      tick(); wbStart = 1'b0;
      tick();
   endtask

   task automatic do_link(input logic [4:0] d, input logic [31:0] pc);
      int e;
      e = cyc + 1;
      e_busy[e] = 1'b1;
      commit(e + 1, 5'd30, pc);
      set_instr(1'b1, 1'b1, 1'b1, d, 32'h5555_0000, pc);
      tick(); wbStart = 1'b0;
      tick();
   endtask

   task automatic nowrite(input logic [4:0] d);
      int e;
      e = cyc + 1;
      e_done[e] = 1'b1;
      set_instr(1'b0, 1'b1, 1'b0, d, 32'h6666_0000, 32'h0);
      tick(); wbStart = 1'b0;
   endtask

   // load with data valid dly edges after the accepting edge; optional stray wbStart while waiting
   task automatic load(input logic [4:0] d, input int dly, input logic [31:0] val, input bit inject);
      int e;
      e = cyc + 1;
      for (int k = 0; k <= dly; k++) e_busy[e + k] = 1'b1;
      commit(e + dly + 1, d, val);
      set_instr(1'b1, 1'b1, 1'b0, d, 32'h7777_0000, 32'h0);
      tick(); wbStart = 1'b0;
      for (int k = 1; k < dly; k++) begin
         if (inject && k == 1) set_instr(1'b1, 1'b0, 1'b0, 5'd12, 32'd77, 32'h0);
         tick(); wbStart = 1'b0;
      end
      chk("lit_busy_wait", 32'(busy), 32'd1);
      memDataValid = 1'b1; memReadData = val;
      tick();
      memDataValid = 1'b0; memReadData = 32'hFFFF_0000;
      tick();
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset(2);
      checking = 1'b1;
      chk("lit_reset_regWrite", 32'(regWrite), 32'd0);
      chk("lit_reset_writeData", writeData, 32'd0);
      chk("lit_reset_wbCount", 32'(wbCount), 32'd0);
      chk("lit_reset_memTimeout", 32'(memTimeout), 32'd0);

      alu(5'd5, 32'h0000_00A5);
      chk("lit_alu_regWrite", 32'(regWrite), 32'd1);
      chk("lit_alu_writeRegister", 32'(writeRegister), 32'd5);
      chk("lit_alu_writeData", writeData, 32'h0000_00A5);
      chk("lit_alu_wbDone", 32'(wbDone), 32'd1);
      chk("lit_alu_wbCount", 32'(wbCount), 32'd1);
      tick();
      chk("lit_alu_regWrite_drop", 32'(regWrite), 32'd0);
      chk("lit_alu_hold_data", writeData, 32'h0000_00A5);

      load(5'd9, 3, 32'hDEAD_BEEF, 1'b1);
      chk("lit_load_regWrite", 32'(regWrite), 32'd1);
      chk("lit_load_writeRegister", 32'(writeRegister), 32'd9);
      chk("lit_load_writeData", writeData, 32'hDEAD_BEEF);
      chk("lit_load_wbCount", 32'(wbCount), 32'd2);

      alu(5'd31, 32'h0000_1234);
      chk("lit_xzr_wbDone", 32'(wbDone), 32'd1);
      chk("lit_xzr_regWrite", 32'(regWrite), 32'd0);
      chk("lit_xzr_wbCount", 32'(wbCount), 32'd2);

      do_link(5'd7, 32'h0000_0104);
      chk("lit_link_writeRegister", 32'(writeRegister), 32'd30);
      chk("lit_link_writeData", writeData, 32'h0000_0104);

      nowrite(5'd3);
      chk("lit_nowrite_wbDone", 32'(wbDone), 32'd1);
      chk("lit_nowrite_regWrite", 32'(regWrite), 32'd0);
      tick();

      memDataValid = 1'b1; memReadData = 32'h0BAD_0BAD;
      tick();
      memDataValid = 1'b0;
      tick();

      alu(5'd1, 32'h0000_0001);
      alu(5'd2, 32'hFFFF_FFFF);
      alu(5'd30, 32'h8000_0000);
      alu(5'd0, 32'h5A5A_5A5A);
      load(5'd6, 15, 32'h1357_9BDF, 1'b0);
      tick();

`ifdef WB_MEM_TIMEOUT_EN
      begin
         int e;
         e = cyc + 1;
         for (int k = 0; k < 15; k++) e_busy[e + k] = 1'b1;
         e_done[e + 15] = 1'b1;
         e_to[e + 15] = 1'b1;
         set_instr(1'b1, 1'b1, 1'b0, 5'd11, 32'h0, 32'h0);
         tick(); wbStart = 1'b0;
         for (int k = 1; k < 16; k++) tick();
         chk("lit_to_memTimeout", 32'(memTimeout), 32'd1);
         chk("lit_to_wbDone", 32'(wbDone), 32'd1);
         chk("lit_to_regWrite", 32'(regWrite), 32'd0);
      end
      alu(5'd13, 32'h0000_0D0D);
      chk("lit_to_sticky", 32'(memTimeout), 32'd1);
`else
      load(5'd4, 20, 32'hCAFE_F00D, 1'b0);
      chk("lit_nto_memTimeout", 32'(memTimeout), 32'd0);
`endif
      tick();

      begin
         int e;
         e = cyc + 1;
         e_busy[e] = 1'b1; e_busy[e + 1] = 1'b1;
         set_instr(1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 32'h0);
         tick(); wbStart = 1'b0;
         tick();
         apply_reset(1);
         memDataValid = 1'b1; memReadData = 32'h2222_3333;
         tick();
         memDataValid = 1'b0;
         tick();
         chk("lit_abort_regWrite", 32'(regWrite), 32'd0);
         chk("lit_abort_wbDone", 32'(wbDone), 32'd0);
         chk("lit_abort_busy", 32'(busy), 32'd0);
         chk("lit_abort_wbCount", 32'(wbCount), 32'd0);
         chk("lit_abort_writeData", writeData, 32'd0);
         chk("lit_abort_writeRegister", 32'(writeRegister), 32'd0);
      end

      for (int k = 0; k < 255; k++) alu(5'(k % 31), 32'h00C0_0000 + 32'(k));
      chk("lit_wrap_full", 32'(wbCount), 32'h0000_00FF);
      alu(5'd17, 32'hABCD_0017);
      chk("lit_wrap_zero", 32'(wbCount), 32'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final stage of the multi-cycle LEGv8 datapath; the writer side of the register-file write port (regWrite / writeRegister / writeData) consumed by the operation-prep stage.
- Captures a retiring instruction's result (ALU result, D-cache load data, or link address) and commits it to the register file as a single one-cycle write strobe.
- Enforces XZR (X31) write suppression and BL link-register (X30) writes.
- Waits on the D-cache data handshake for loads and keeps a committed-write counter.

Parameters:
DATA_WIDTH, 32, width of writeData, aluResult, memReadData, pcPlus4
COUNT_WIDTH, 16, width of wbCount
MEM_TIMEOUT, 15, max cycles in WAIT_MEM (used only with the optional feature)

Ports:
clock  input  1  main clock, all logic on posedge
reset  input  1  synchronous active-high reset
wbStart  input  1  retiring instruction presented this cycle
wbRegWrite  input  1  instruction writes a register
memToReg  input  1  1 = result comes from D-cache, 0 = ALU
link  input  1  BL: write pcPlus4 to X30
destReg  input  5  destination register address
aluResult  input  DATA_WIDTH  ALU result
pcPlus4  input  DATA_WIDTH  return address for BL
memReadData  input  DATA_WIDTH  D-cache load data
memDataValid  input  1  memReadData valid this cycle
regWrite  output  1  register-file write strobe (registered)
writeRegister  output  5  register-file write address (registered)
writeData  output  DATA_WIDTH  register-file write data (registered)
busy  output  1  state != IDLE (combinational)
wbDone  output  1  one-cycle pulse when the instruction retires
wbCount  output  COUNT_WIDTH  number of committed register writes
memTimeout  output  1  sticky load-timeout flag

Behaviour:
- Reset (synchronous, active-high) takes priority over all other activity. On reset:
  - regWrite=0, writeRegister=0, writeData=0, wbDone=0, wbCount=0, memTimeout=0.
  - State goes to IDLE; internal capture registers are cleared.
- Reset asserted mid-operation (WAIT_MEM or WRITE) aborts the instruction with no write and no wbDone.
- States: IDLE, WAIT_MEM, WRITE.
- IDLE, on wbStart=1, captures destReg, aluResult, pcPlus4, link, memToReg and wbRegWrite, then transitions:
  - wbRegWrite=0: stay in IDLE and pulse wbDone the next cycle; no write, wbCount unchanged.
  - wbRegWrite=1 and link=1: go to WRITE with data=pcPlus4 and reg=30. link overrides memToReg and destReg.
  - wbRegWrite=1 and memToReg=1: go to WAIT_MEM.
  - otherwise: go to WRITE with data=aluResult and reg=destReg.
- WAIT_MEM: on memDataValid=1, capture memReadData and go to WRITE. memDataValid is ignored in every other state.
- WRITE (lasts exactly one cycle):
  - Next edge sets regWrite=1, writeRegister=captured reg, writeData=captured data, wbDone=1; returns to IDLE.
  - If the captured reg is 31 (XZR), regWrite stays 0 and wbCount is not incremented, but wbDone still pulses.
  - wbCount increments by 1 per committed write and wraps from all-ones to 0.
- regWrite and wbDone are high for exactly one cycle per instruction. Between writes, writeRegister and writeData hold their last values; they never float (no high-Z "not ready" encoding).
- wbStart while busy=1 is ignored. Upstream must hold wbStart until busy=0.
- wbStart in the same cycle the registered regWrite pulse is visible (state already IDLE) is accepted normally, giving back-to-back retirement.
- Latency:
  - ALU/link path: wbStart at edge N gives regWrite high after edge N+1.
  - Load path: memDataValid sampled at edge M gives regWrite high after edge M+1.

Optional Feature:
WB_MEM_TIMEOUT_EN
- Defined:
  - A counter of width clog2(MEM_TIMEOUT+1) clears on entry to WAIT_MEM and increments each cycle without memDataValid.
  - If the counter reaches MEM_TIMEOUT, the instruction is aborted: memTimeout is set (sticky until reset), wbDone pulses, no register write occurs, and the state returns to IDLE.
  - memDataValid in the same cycle the count reaches MEM_TIMEOUT wins: normal write, no timeout.
- Undefined: WAIT_MEM waits indefinitely, memTimeout is tied to 0, and no counter logic is generated.

Test Plan:
- Reset, then wbStart with wbRegWrite=1, memToReg=0, destReg=5, aluResult=32'h0000_00A5 -> one cycle later regWrite=1, writeRegister=5, writeData=32'h0000_00A5, wbDone=1, wbCount=1; the following cycle regWrite=0.
- Load to destReg=9, memDataValid asserted 3 cycles later with memReadData=32'hDEAD_BEEF -> busy=1 for the wait; regWrite=1, writeRegister=9, writeData=32'hDEAD_BEEF one cycle after valid.
- destReg=31, aluResult=32'h1234 -> wbDone=1, regWrite stays 0, wbCount unchanged.
- link=1, pcPlus4=32'h0000_0104, destReg=7 -> writeRegister=30, writeData=32'h0000_0104. Also: wbStart asserted during WAIT_MEM -> ignored, only the first instruction commits.
- Reset asserted during WAIT_MEM, then memDataValid=1 -> no regWrite, no wbDone, all outputs 0. Also: preload wbCount to 16'hFFFF via 65535 commits, one more commit -> wbCount=0.
- WB_MEM_TIMEOUT_EN defined, MEM_TIMEOUT=15, load with no memDataValid -> after 15 cycles memTimeout=1, wbDone=1, regWrite=0; memTimeout remains 1 through later normal writes until reset.
